// File: rtl/blk_raster_buf.sv
// Raster-to-block front end: buffers 8-line strips in a ping-pong store and replays
// each 8x8 block as eight column words, spaced BLK_PERIOD cycles apart.
module blk_raster_buf #(
    parameter int PIC_PIX_IN_WIDTH = 8,
    parameter int IMG_WIDTH        = 64,
    parameter int IMG_HEIGHT       = 64,
    parameter int BLK_PERIOD       = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          pix_valid_i,
    input  logic                          pix_sof_i,
    input  logic [PIC_PIX_IN_WIDTH-1:0]   pix_data_i,
    output logic                          pix_ready_o,
    output logic                          pic_frame_o,
    output logic                          pic_blk_go_o,
    output logic [PIC_PIX_IN_WIDTH*8-1:0] pic_data_out_o,
    output logic                          busy_o
);

    localparam int W       = PIC_PIX_IN_WIDTH;
    localparam int NBLK    = IMG_WIDTH / 8;
    localparam int NSTRIP  = IMG_HEIGHT / 8;
    localparam int GAP_LEN = BLK_PERIOD - 8;
    localparam int CW      = $clog2(IMG_WIDTH);
    localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int SW      = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t state, state_nxt;

    logic [W-1:0]    mem [2][8][IMG_WIDTH];
    logic [CW-1:0]   col, wr_col, rd_col;
    logic [2:0]      line, wr_line;
    logic [SW-1:0]   strip, wr_strip;
    logic            wb, rb;
    logic [1:0]      full, fof;
    logic [2:0]      k;
    logic [BW-1:0]   blk;
    logic [GW-1:0]   gcnt;
    logic            accept, last_col, fill, last_blk, release_bank;

    assign pix_ready_o = ~full[wb];
    assign accept      = pix_valid_i & pix_ready_o;

    // A start-of-frame pixel restarts the strip at (0,0), dropping the partial strip in wb.
    assign wr_col   = pix_sof_i ? '0 : col;
    assign wr_line  = pix_sof_i ? '0 : line;
    assign wr_strip = pix_sof_i ? '0 : strip;
    assign last_col = (wr_col == CW'(IMG_WIDTH - 1));
    assign fill     = accept & last_col & (wr_line == 3'd7);

    assign last_blk     = (blk == BW'(NBLK - 1));
    assign release_bank = (state == SEND) & (k == 3'd7) & last_blk;
    assign rd_col       = CW'({blk, k});

    assign busy_o = (|full) | (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (accept)
            mem[wb][wr_line][wr_col] <= pix_data_i;
    end

    // Write counters and bank bookkeeping; fill of wb and release of rb never hit the same bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col   <= '0;
            line  <= '0;
            strip <= '0;
            wb    <= 1'b0;
            rb    <= 1'b0;
            full  <= '0;
            fof   <= '0;
        end else begin
            if (accept) begin
                col   <= last_col ? '0 : wr_col + CW'(1);
                line  <= last_col ? wr_line + 3'd1 : wr_line;
                strip <= wr_strip;
                if (fill)
                    strip <= (wr_strip == SW'(NSTRIP - 1)) ? '0 : wr_strip + SW'(1);
            end
            if (fill) begin
                full[wb] <= 1'b1;
                fof[wb]  <= (wr_strip == '0);
                wb       <= ~wb;
            end
            if (release_bank) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k    <= '0;
            blk  <= '0;
            gcnt <= '0;
        end else begin
            case (state)
                SEND: begin
                    k    <= k + 3'd1;
                    gcnt <= '0;
                    if (k == 3'd7)
                        blk <= last_blk ? '0 : blk + BW'(1);
                end
                GAP: begin
                    k    <= '0;
                    gcnt <= gcnt + GW'(1);
                end
                default: begin
                    k    <= '0;
                    blk  <= '0;
                    gcnt <= '0;
                end
            endcase
        end
    end

    // Banks are filled alternately, so reading rb in turn always serves the oldest strip.
    always_comb begin
        state_nxt      = state;
        pic_blk_go_o   = 1'b0;
        pic_frame_o    = 1'b0;
        pic_data_out_o = '0;
        case (state)
            IDLE: begin
                if (full[rb])
                    state_nxt = SEND;
            end
            SEND: begin
                pic_blk_go_o = (k == 3'd0);
                pic_frame_o  = (k == 3'd0) & (blk == '0) & fof[rb];
                for (int r = 0; r < 8; r++)
                    pic_data_out_o[r*W +: W] = mem[rb][r][rd_col];
                if (k == 3'd7) begin
                    if (last_blk && !full[~rb])
                        state_nxt = IDLE;
                    else
                        state_nxt = (GAP_LEN == 0) ? SEND : GAP;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_LEN - 1))
                    state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_blk_raster_buf.sv
// Bench for blk_raster_buf: a 16x8 instance for latency, spacing and reset, and a
// 64x64 instance with a long block period for backpressure, start-of-frame and frame tagging.
module tb_blk_raster_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst = 1'b1, a_valid = 1'b0, a_sof = 1'b0;
    logic [7:0]  a_pix = '0;
    logic        a_ready, a_frame, a_go, a_busy;
    logic [63:0] a_data;

    logic        b_rst = 1'b1, b_valid = 1'b0, b_sof = 1'b0;
    logic [7:0]  b_pix = '0;
    logic        b_ready, b_frame, b_go, b_busy;
    logic [63:0] b_data;

    blk_raster_buf #(.PIC_PIX_IN_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(8), .BLK_PERIOD(16)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .pix_valid_i(a_valid), .pix_sof_i(a_sof), .pix_data_i(a_pix),
        .pix_ready_o(a_ready), .pic_frame_o(a_frame), .pic_blk_go_o(a_go),
        .pic_data_out_o(a_data), .busy_o(a_busy));

    // Block period 80 makes reading a strip (7*80+8 cycles) slower than writing one (512).
    blk_raster_buf #(.PIC_PIX_IN_WIDTH(8), .IMG_WIDTH(64), .IMG_HEIGHT(64), .BLK_PERIOD(80)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .pix_valid_i(b_valid), .pix_sof_i(b_sof), .pix_data_i(b_pix),
        .pix_ready_o(b_ready), .pic_frame_o(b_frame), .pic_blk_go_o(b_go),
        .pic_data_out_o(b_data), .busy_o(b_busy));

    logic [63:0] exp_a[$], exp_b[$];
    logic        exp_af[$], exp_bf[$];

    int a_cnt = 0, b_cnt = 0;
    int ncyc = 0, b_gos = 0, b_frames = 0;
    int go1_idx = -1, go8_idx = -1, fall_idx = -1, rise_idx = -1;
    int sum_in = 0, sum_out = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int seed, input int l, input int c);
        return 8'(seed * 29 + l * 16 + c);
    endfunction

    function automatic logic [63:0] col_word(input int seed, input int c);
        logic [63:0] w;
        for (int r = 0; r < 8; r++) w[r*8 +: 8] = pix_val(seed, r, c);
        return w;
    endfunction

    task automatic drive_a(input int seed);
        int n;
        for (int b = 0; b < 2; b++) begin
            exp_af.push_back(b == 0);
            for (int k = 0; k < 8; k++) exp_a.push_back(col_word(seed, b * 8 + k));
        end
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_pix   = pix_val(seed, i / 16, i % 16);
            n = 0;
            while (!a_ready && n < 2000) begin @(negedge clk); n++; end
            if (n == 2000) chk("a_ready_timeout", 64'(a_ready), 64'd1);
        end
    endtask

    task automatic drive_b(input int seed, input int npix, input logic first, input logic sof_first);
        int n;
        if (npix == 512) begin
            for (int b = 0; b < 8; b++) begin
                exp_bf.push_back(first && b == 0);
                for (int k = 0; k < 8; k++) exp_b.push_back(col_word(seed, b * 8 + k));
            end
        end
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_sof   = sof_first && (i == 0);
            b_pix   = pix_val(seed, i / 64, i % 64);
            if (npix == 512) sum_in += int'(b_pix);
            n = 0;
            while (!b_ready && n < 2000) begin @(negedge clk); n++; end
            if (n == 2000) chk("b_ready_timeout", 64'(b_ready), 64'd1);
        end
    endtask

    always @(negedge clk) begin
        if (a_rst) begin
            a_cnt = 0;
        end else begin
            if (a_go) begin
                chk("a_go_expected", 64'(exp_a.size() >= 8 && a_cnt == 0), 64'd1);
                if (exp_a.size() >= 8) begin
                    a_cnt = 8;
                    chk("a_frame", 64'(a_frame), 64'(exp_af.pop_front()));
                end
            end else begin
                chk("a_frame_nogo", 64'(a_frame), 64'd0);
            end
            if (a_cnt > 0) begin
                chk("a_word", a_data, exp_a.pop_front());
                a_cnt--;
            end else begin
                chk("a_data_idle", a_data, 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (b_rst) begin
            b_cnt = 0;
        end else begin
            if (!b_ready && fall_idx < 0) fall_idx = ncyc;
            if (b_ready && fall_idx >= 0 && rise_idx < 0) rise_idx = ncyc;
            if (b_go) begin
                b_gos++;
                if (b_gos == 1) go1_idx = ncyc;
                if (b_gos == 8) go8_idx = ncyc;
                if (b_frame) b_frames++;
                chk("b_go_expected", 64'(exp_b.size() >= 8 && b_cnt == 0), 64'd1);
                if (exp_b.size() >= 8) begin
                    b_cnt = 8;
                    chk("b_frame", 64'(b_frame), 64'(exp_bf.pop_front()));
                end
            end else begin
                chk("b_frame_nogo", 64'(b_frame), 64'd0);
            end
            if (b_cnt > 0) begin
                chk("b_word", b_data, exp_b.pop_front());
                for (int r = 0; r < 8; r++) sum_out += int'(b_data[r*8 +: 8]);
                b_cnt--;
            end else begin
                chk("b_data_idle", b_data, 64'd0);
            end
        end
    end

    initial begin
        int n;
        int gos;

        repeat (3) @(negedge clk);
        chk("a_rst_ready", 64'(a_ready), 64'd1);
        chk("a_rst_go",    64'(a_go),    64'd0);
        chk("a_rst_frame", 64'(a_frame), 64'd0);
        chk("a_rst_data",  a_data,       64'd0);
        chk("a_rst_busy",  64'(a_busy),  64'd0);
        chk("b_rst_ready", 64'(b_ready), 64'd1);
        chk("b_rst_busy",  64'(b_busy),  64'd0);
        chk("b_rst_data",  b_data,       64'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Latency, block contents and go spacing on the 16x8 instance.
        drive_a(0);
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_lat_t1_go", 64'(a_go), 64'd0);
        chk("a_lat_t1_busy", 64'(a_busy), 64'd1);
        @(negedge clk);
        chk("a_lat_t2_go", 64'(a_go), 64'd1);
        chk("a_blk0_frame", 64'(a_frame), 64'd1);
        chk("a_blk0_w0", a_data, 64'h7060_5040_3020_1000);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            chk("a_go_spacing", 64'(a_go), 64'(i == 16));
            if (i >= 8 && i <= 15) chk("a_gap_data", a_data, 64'd0);
            if (i == 16) begin
                chk("a_blk1_w0", a_data, 64'h7868_5848_3828_1808);
                chk("a_blk1_frame", 64'(a_frame), 64'd0);
            end
        end
        chk("a_idle_busy", 64'(a_busy), 64'd0);

        // Reset in the middle of a block.
        drive_a(3);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while (!a_go && n < 20) begin @(negedge clk); n++; end
        chk("a_go_seen", 64'(a_go), 64'd1);
        repeat (4) @(negedge clk);
        #1 a_rst = 1'b1;
        @(negedge clk);
        chk("a_mrst_go",    64'(a_go),    64'd0);
        chk("a_mrst_frame", 64'(a_frame), 64'd0);
        chk("a_mrst_data",  a_data,       64'd0);
        chk("a_mrst_busy",  64'(a_busy),  64'd0);
        chk("a_mrst_ready", 64'(a_ready), 64'd1);
        #1;
        exp_a.delete();
        exp_af.delete();
        a_rst = 1'b0;
        gos = 0;
        repeat (40) begin @(negedge clk); if (a_go) gos++; end
        chk("a_no_go_after_rst", 64'(gos), 64'd0);
        drive_a(4);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while ((exp_a.size() != 0 || a_busy) && n < 200) begin @(negedge clk); n++; end
        chk("a_drain", 64'(exp_a.size()), 64'd0);

        // Two back-to-back frames with continuous input on the 64x64 instance.
        for (int s = 0; s < 16; s++) drive_b(s + 1, 512, (s % 8) == 0, 1'b0);
        @(negedge clk);
        b_valid = 1'b0;
        n = 0;
        while ((exp_b.size() != 0 || b_busy) && n < 6000) begin @(negedge clk); n++; end
        chk("b_drain1", 64'(exp_b.size()), 64'd0);
        chk("b_ready_fall", 64'(fall_idx - go1_idx), 64'd511);
        chk("b_ready_rise", 64'(rise_idx - go8_idx), 64'd8);
        chk("b_frames_2", 64'(b_frames), 64'd2);

        // Start-of-frame in the middle of a strip.
        drive_b(17, 512, 1'b1, 1'b0);
        drive_b(18, 197, 1'b0, 1'b0);
        drive_b(19, 512, 1'b1, 1'b1);
        drive_b(20, 512, 1'b0, 1'b0);
        @(negedge clk);
        b_valid = 1'b0;
        b_sof   = 1'b0;
        n = 0;
        while ((exp_b.size() != 0 || b_busy) && n < 6000) begin @(negedge clk); n++; end
        chk("b_drain2", 64'(exp_b.size()), 64'd0);
        chk("b_frames_4", 64'(b_frames), 64'd4);
        chk("b_checksum", 64'(sum_out), 64'(sum_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
